// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, binary index and valid.
// The owner keeps the grant up to max_hold cycles under contention, then rotation is forced.
module rr_arb8 #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       valid
);

   localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] hold_q, hold_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] id_q, id_d;
   logic       valid_q, valid_d;

   logic [2:0] win;
   logic       others;

   // First set bit searching upward from p+1; p itself is visited last.
   function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      logic [2:0] w;
      logic       hit;
      w   = p;
      hit = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         idx = p + 3'(i);
         if (!hit && r[idx]) begin
            w   = idx;
            hit = 1'b1;
         end
      end
      return w;
   endfunction

   always_comb begin
      win    = pick(req, ptr_q);
      others = |(req & ~(8'b1 << ptr_q));
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      valid_d = valid_q;

      unique case (state_q)
         StIdle: begin
            gnt_d   = 8'h00;
            id_d    = 3'd0;
            valid_d = 1'b0;
            hold_d  = 4'd0;
            if (en && (req != 8'h00)) begin
               state_d = StGrant;
               ptr_d   = win;
               hold_d  = 4'd1;
               gnt_d   = 8'b1 << win;
               id_d    = win;
               valid_d = 1'b1;
            end
         end
         StGrant: begin
            if (!en || (!req[ptr_q] && !others)) begin
               state_d = StIdle;
               hold_d  = 4'd0;
               gnt_d   = 8'h00;
               id_d    = 3'd0;
               valid_d = 1'b0;
            end else if (!req[ptr_q] || ((hold_q >= MaxHold) && others)) begin
               ptr_d   = win;
               hold_d  = 4'd1;
               gnt_d   = 8'b1 << win;
               id_d    = win;
               valid_d = 1'b1;
            end else if (hold_q < MaxHold) begin
               hold_d = hold_q + 4'd1;
            end else begin
               hold_d = MaxHold;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= 3'd7;
         hold_q  <= 4'd0;
         gnt_q   <= 8'h00;
         id_q    <= 3'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         valid_q <= valid_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = id_q;
   assign valid  = valid_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Scoreboard bench for rr_arb8: two instances (tenure 4 and 1) share stimulus and are
// checked each cycle against an integer reference model of the rotation rules.
module tb_rr_arb8;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt4, gnt1;
   logic [2:0] id4, id1;
   logic       valid4, valid1;

   typedef struct packed {
      logic [7:0] g;
      logic [2:0] id;
      logic       v;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];

   int compared   = 0;
   int mismatched = 0;

   int owner[2];
   int ptr[2];
   int ten[2];
   int mh[2];

   always #5 clk = ~clk;

   rr_arb8 #(.MAX_HOLD(4)) u_dut4 (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .req    (req),
      .gnt    (gnt4),
      .gnt_id (id4),
      .valid  (valid4)
   );

   rr_arb8 #(.MAX_HOLD(1)) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .req    (req),
      .gnt    (gnt1),
      .gnt_id (id1),
      .valid  (valid1)
   );

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Next requester after position p in circular order, or -1 when none is requesting.
   function automatic int next_after(input int p, input logic [7:0] r);
      for (int k = 1; k <= 8; k++) begin
         if (r[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   task automatic model_step(input int i, input logic r_rst, input logic r_en,
                             input logic [7:0] r, output exp_t e);
      int w;
      if (r_rst) begin
         owner[i] = -1; ptr[i] = 7; ten[i] = 0;
      end else if (!r_en) begin
         owner[i] = -1; ten[i] = 0;
      end else begin
         w = next_after(ptr[i], r);
         if (owner[i] < 0) begin
            if (w >= 0) begin owner[i] = w; ptr[i] = w; ten[i] = 1; end
         end else if (r[owner[i]]) begin
            if (ten[i] < mh[i]) ten[i]++;
            else if (w != owner[i]) begin owner[i] = w; ptr[i] = w; ten[i] = 1; end
         end else if (w >= 0) begin
            owner[i] = w; ptr[i] = w; ten[i] = 1;
         end else begin
            owner[i] = -1; ten[i] = 0;
         end
      end
      e.v  = (owner[i] >= 0);
      e.g  = e.v ? (8'h01 << owner[i]) : 8'h00;
      e.id = e.v ? 3'(owner[i]) : 3'd0;
   endtask

   task automatic cyc(input logic r_rst, input logic r_en, input logic [7:0] r);
      exp_t e;
      @(negedge clk);
      rst = r_rst;
      en  = r_en;
      req = r;
      model_step(0, r_rst, r_en, r, e);
      q4.push_back(e);
      model_step(1, r_rst, r_en, r, e);
      q1.push_back(e);
   endtask

   task automatic run(input logic r_en, input logic [7:0] r, input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, r_en, r);
   endtask

   // Monitor: one output per clock from each instance, compared against the queued model.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         check("gnt_h4", gnt4, e.g);
         check("id_h4", id4, e.id);
         check("valid_h4", valid4, e.v);
         check("onehot_h4", ($countones(gnt4) <= 1), 1);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check("gnt_h1", gnt1, e.g);
         check("id_h1", id1, e.id);
         check("valid_h1", valid1, e.v);
         check("onehot_h1", ($countones(gnt1) <= 1), 1);
      end
   end

   initial begin
      mh[0] = 4;
      mh[1] = 1;
      for (int i = 0; i < 2; i++) begin owner[i] = -1; ptr[i] = 7; ten[i] = 0; end
      rst = 1'b1;
      en  = 1'b0;
      req = 8'h00;

      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b1, 8'h05);
      // back-to-back handoff on release
      run(1'b1, 8'h05, 2);
      run(1'b1, 8'h04, 3);
      run(1'b1, 8'h00, 2);
      // full contention, tenure rotation with 7->0 wrap
      run(1'b1, 8'hFF, 36);
      run(1'b1, 8'h00, 1);
      // single requester saturates tenure
      run(1'b1, 8'h80, 20);
      run(1'b1, 8'h00, 2);
      // owner 3, enable dropped, then search resumes from 4
      cyc(1'b1, 1'b0, 8'h00);
      run(1'b1, 8'h08, 2);
      run(1'b0, 8'h09, 1);
      run(1'b1, 8'h09, 3);
      // tenure 1 alternation
      cyc(1'b1, 1'b0, 8'h00);
      run(1'b1, 8'h11, 8);
      // asynchronous reset during owner 2's tenure
      cyc(1'b1, 1'b0, 8'h00);
      run(1'b1, 8'h3C, 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_gnt_h4", gnt4, 0);
      check("async_rst_valid_h4", valid4, 0);
      check("async_rst_gnt_h1", gnt1, 0);
      check("async_rst_id_h1", id1, 0);
      cyc(1'b1, 1'b1, 8'h3C);
      run(1'b1, 8'h3C, 6);

      for (int k = 0; k < 600; k++) begin
         logic [7:0] r;
         r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
         if ($urandom_range(0, 7) == 0) r = 8'h00;
         cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 15) != 0), r);
      end

      run(1'b1, 8'h00, 1);
      @(posedge clk);
      #2;
      check("queue_drained", q4.size() + q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
- Eight-requester round-robin arbiter with grant hold and bounded tenure.
- Shares a single downstream resource (bus or encoder-fed datapath) among 8 requesters.
- Produces a registered one-hot grant plus its 3-bit binary index and a valid flag, matching the team's 8-to-3 encoder output convention.
- Rotating priority prevents starvation; a tenure limit forces rotation under contention.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant while others wait; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbiter enable; low forces idle.
- req  input  8  request vector, bit i = requester i.
- gnt  output  8  registered one-hot grant; all zero when idle.
- gnt_id  output  3  binary index of granted requester; 0 when idle.
- valid  output  1  1 when gnt is non-zero.

Behaviour:
- Reset (async, immediate):
  - Outputs: gnt=0, gnt_id=0, valid=0.
  - Internal: state=IDLE, ptr=7, hold_cnt=0.
  - Reset asserted mid-grant drops the grant immediately; no completion.
- Search order: start at index ptr+1 (mod 8) and wrap upward. The first set req bit in that order wins. The previous owner is therefore always lowest priority.
- Registered outputs: req sampled at rising edge k; grant visible after edge k. No combinational req->gnt path.
- States:
  - IDLE:
    - At an edge with en=1 and req!=0: grant winner W, gnt=1<<W, gnt_id=W, valid=1, ptr=W, hold_cnt=1, go to GRANT.
    - Otherwise outputs stay 0.
  - GRANT (owner O=ptr):
    - en=0: gnt=0, valid=0, gnt_id=0, hold_cnt=0, go to IDLE. ptr is retained.
    - req[O]=0 (release) with other requests pending: grant next winner in the same edge (back-to-back, no idle cycle), ptr=W, hold_cnt=1.
    - req[O]=0 with no other requests: go to IDLE, outputs cleared.
    - req[O]=1, hold_cnt<MAX_HOLD: keep the grant, hold_cnt+1.
    - req[O]=1, hold_cnt>=MAX_HOLD, another req bit set: forced rotation to next winner (search from O+1), ptr=W, hold_cnt=1.
    - req[O]=1, hold_cnt>=MAX_HOLD, no other request: keep the grant, hold_cnt saturates at MAX_HOLD.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id == index of set bit.
  - valid == |gnt.
- Widths: ptr 3-bit with natural mod-8 wrap (7+1 -> 0); hold_cnt 4-bit.
- MAX_HOLD=1: under contention, ownership rotates every cycle.
- Simultaneous release and new request from the same requester at one edge: treated as req[O]=1, i.e. hold.
- Requests are level-sensitive. Requester i must hold req[i] until granted; dropping it earlier is legal and simply withdraws the request.

Test Plan:
1. Reset, en=1, req=8'b0000_0101 -> after first edge gnt=8'h01, gnt_id=0, valid=1. Drop req[0] -> next edge gnt=8'h04, gnt_id=2, with no idle cycle.
2. MAX_HOLD=4, req=8'hFF held constant -> each owner keeps the grant exactly 4 cycles. Owner sequence 0,1,2,...,7,0; wrap 7->0 checked.
3. Single requester req=8'h80 held 20 cycles -> gnt=8'h80, gnt_id=7 for all 20 cycles (saturated tenure, no drop). Then req=0 -> next edge valid=0, gnt=0.
4. Owner 3 granted, deassert en for one cycle, then re-enable with req=8'h09 -> gnt goes 0 while en=0. Next grant goes to 0, since ptr=3 makes the search order 4..7,0.
5. req=8'h3C, assert rst asynchronously mid-cycle during owner 2's tenure -> gnt=0, valid=0 before the next clock edge. After release the first grant is index 2 (ptr reset to 7, search from 0, lowest set bit 2).
6. MAX_HOLD=1, req=8'h11 -> gnt alternates 8'h01, 8'h10 every cycle. gnt_id alternates 0,4; one-hot assertion holds throughout.
